bc_level_ctrl: RTL and testbench
================================

BC_LEVEL_CTRL -- requirements
Module: bc_level_ctrl

Interface
REQ-001 SHALL have parameter MAX_BOX, default 3, meaning log2 of base image side (base level holds 4^MAX_BOX cells).
REQ-002 SHALL have parameter LVL_W, default 4, meaning width of the level output; LVL_W SHALL be at least clog2(MAX_BOX+1).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a box-count run.
REQ-006 SHALL have port load_done  input  1  pixel loader has finished writing the base level.
REQ-007 SHALL have port sqg_wen  input  1  reducer write strobe, one pulse per reduced cell.
REQ-008 SHALL have port bc_mode  output  1  high = loader owns RAM and reducer held in restart.
REQ-009 SHALL have port level  output  LVL_W  level currently being reduced (source side = 2^level).
REQ-010 SHALL have port ram_sel  output  1  ping-pong RAM region select; reducer reads region ram_sel and writes region ~ram_sel.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port level_valid  output  1  one-cycle pulse when a level's last write is accepted.
REQ-013 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-014 SHALL have port err  output  1  sticky watchdog error (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, REDUCE, GAP, FINISH.
REQ-016 IDLE: bc_mode=1, busy=0; start=1 -> LOAD next cycle; start ignored in all other states.
REQ-017 LOAD: bc_mode=1; on load_done=1 -> REDUCE with level=MAX_BOX, ram_sel=0, write counter=4^(MAX_BOX-1).
REQ-018 REDUCE: bc_mode=0; each cycle with sqg_wen=1 decrements the write counter; sqg_wen outside REDUCE SHALL be ignored.
REQ-019 REDUCE: sqg_wen=1 while counter==1 -> level_valid=1 that cycle (combinational on sqg_wen in REDUCE) and next state GAP.
REQ-020 GAP: exactly one cycle; bc_mode=1 (restarts reducer addressing); on GAP entry, level decrements by 1 and ram_sel toggles.
REQ-021 GAP exit: level!=0 -> REDUCE with counter=4^(level-1); level==0 -> FINISH.
REQ-022 FINISH: done=1 for exactly one cycle, bc_mode=1, then IDLE; level stays 0 until next LOAD.
REQ-023 Write counter width SHALL be 2*MAX_BOX-1 bits minimum; counter SHALL never wrap below 1 in REDUCE.
REQ-024 load_done and start asserted in the same cycle in IDLE: only start acts; load_done SHALL be sampled from the first LOAD cycle.
REQ-025 Outputs bc_mode, level, ram_sel, busy, done SHALL be registered or decoded from registered state only.

Reset
REQ-026 RST=1 at a clock edge SHALL force IDLE from any state, including mid-REDUCE, in that same edge.
REQ-027 Reset values: bc_mode=1, level=0, ram_sel=0, busy=0, level_valid=0, done=0, err=0, write counter=0.

Configuration
REQ-028 Macro BC_TIMEOUT_EN defined: a 5-bit watchdog SHALL clear on each sqg_wen and on entry to REDUCE, increment each REDUCE cycle without sqg_wen; reaching 16 SHALL set err=1 and force IDLE next cycle.
REQ-029 err SHALL remain 1 until RST or the next accepted start; with BC_TIMEOUT_EN defined, start SHALL clear err.
REQ-030 Macro BC_TIMEOUT_EN undefined: no watchdog logic; err tied 0; REDUCE waits indefinitely.

Verification (MAX_BOX=3)
REQ-031 Reset, start pulse, load_done after 5 cycles, sqg_wen every 4th cycle -> level_valid after write 16 (level 3), 4 (level 2), 1 (level 1); 21 writes total; done one pulse; final level=0, ram_sel=1.
REQ-032 Each GAP -> bc_mode=1 for exactly one cycle; ram_sel sequence 0,1,0,1 across levels 3,2,1,end.
REQ-033 start pulsed during REDUCE -> no effect; run completes normally with a single done.
REQ-034 RST asserted after 7th write of level 3 -> next cycle IDLE, busy=0, level=0, bc_mode=1; later start runs a full 21-write sequence.
REQ-035 BC_TIMEOUT_EN defined, sqg_wen stopped after write 5 -> err=1 after 16 idle REDUCE cycles, FSM in IDLE, done never pulses; next start clears err.
REQ-036 sqg_wen pulsed in IDLE/LOAD/GAP -> write counter unchanged, no level_valid.

Source files
------------

// File: rtl/bc_level_ctrl.sv
// Box-count level controller: sequences base-image load, then one reduction pass per level
// with ping-pong RAM selection. Optional watchdog enabled by defining BC_TIMEOUT_EN.
module bc_level_ctrl #(
  parameter int MAX_BOX = 3,
  parameter int LVL_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             load_done,
  input  logic             sqg_wen,
  output logic             bc_mode,
  output logic [LVL_W-1:0] level,
  output logic             ram_sel,
  output logic             busy,
  output logic             level_valid,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (2 * MAX_BOX - 1 < 1) ? 1 : 2 * MAX_BOX - 1;

  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, GAP, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] wr_cnt;
  logic             last_write;

  // Cells written while reducing level lv into level lv-1: 4^(lv-1).
  function automatic logic [CNT_W-1:0] level_size(input logic [LVL_W-1:0] lv);
    return CNT_W'(1) << (2 * (int'(lv) - 1));
  endfunction

  assign last_write  = (state == REDUCE) && sqg_wen && (wr_cnt == CNT_W'(1));
  assign level_valid = last_write;

`ifdef BC_TIMEOUT_EN
  logic [4:0] wd_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees the pre-edge values of state, level and wr_cnt.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      bc_mode <= 1'b1;
      level   <= '0;
      ram_sel <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_cnt  <= '0;
`ifdef BC_TIMEOUT_EN
      wd_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
`ifdef BC_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (load_done) begin
            state   <= REDUCE;
            bc_mode <= 1'b0;
            level   <= LVL_W'(MAX_BOX);
            ram_sel <= 1'b0;
            wr_cnt  <= level_size(LVL_W'(MAX_BOX));
`ifdef BC_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end
        end
        REDUCE: begin
          if (sqg_wen) begin
            wr_cnt <= wr_cnt - CNT_W'(1);
`ifdef BC_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (last_write) begin
              state   <= GAP;
              bc_mode <= 1'b1;
              level   <= level - LVL_W'(1);
              ram_sel <= ~ram_sel;
            end
          end
`ifdef BC_TIMEOUT_EN
          else if (wd_cnt == 5'd15) begin
            wd_cnt  <= wd_cnt + 5'd1;
            err_q   <= 1'b1;
            state   <= IDLE;
            bc_mode <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 5'd1;
          end
`endif
        end
        GAP: begin
          // level already holds the next level to reduce (decremented on GAP entry).
          if (level != '0) begin
            state   <= REDUCE;
            bc_mode <= 1'b0;
            wr_cnt  <= level_size(level);
`ifdef BC_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end else begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          bc_mode <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bc_level_ctrl.sv
// Randomized self-checking bench for bc_level_ctrl against a phase/level reference model.
module tb_bc_level_ctrl;

  localparam int MAX_BOX = 3;
  localparam int LVL_W   = 4;

  logic             CLK = 1'b0;
  logic             RST, start, load_done, sqg_wen;
  logic             bc_mode, ram_sel, busy, level_valid, done, err;
  logic [LVL_W-1:0] level;

  bc_level_ctrl #(.MAX_BOX(MAX_BOX), .LVL_W(LVL_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .load_done(load_done), .sqg_wen(sqg_wen),
    .bc_mode(bc_mode), .level(level), .ram_sel(ram_sel), .busy(busy),
    .level_valid(level_valid), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef enum {P_IDLE, P_LOAD, P_REDUCE, P_GAP, P_FINISH} phase_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: run phase, current level, remaining cells in this level.
  phase_t m_phase = P_IDLE;
  int     m_level = 0;
  int     m_ram   = 0;
  int     m_left  = 0;
  int     m_wd    = 0;
  int     m_err   = 0;
  int     run_writes;

  // Observations taken from the DUT during a run.
  int n_wr, n_done;
  int valid_at[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit do_rst, input bit do_start, input bit do_load, input bit do_wen);
    @(negedge CLK);
    RST = do_rst; start = do_start; load_done = do_load; sqg_wen = do_wen;
    #1;
    check("busy", busy, 32'(m_phase != P_IDLE));
    check("bc_mode", bc_mode, 32'(m_phase != P_REDUCE));
    check("level", level, m_level);
    check("ram_sel", ram_sel, m_ram);
    check("done", done, 32'(m_phase == P_FINISH));
    check("level_valid", level_valid, 32'(m_phase == P_REDUCE && do_wen && m_left == 1));
    check("err", err, m_err);
    if (!bc_mode && do_wen) n_wr++;
    if (level_valid) valid_at.push_back(n_wr);
    if (done) n_done++;
    @(posedge CLK);
    if (do_rst) begin
      m_phase = P_IDLE; m_level = 0; m_ram = 0; m_err = 0; m_wd = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (do_start) begin m_phase = P_LOAD; m_err = 0; end
        P_LOAD: if (do_load) begin
          m_phase = P_REDUCE; m_level = MAX_BOX; m_ram = 0;
          m_left = 4 ** (MAX_BOX - 1); m_wd = 0;
        end
        P_REDUCE: begin
          if (do_wen) begin
            run_writes++;
            m_wd = 0;
            m_left--;
            if (m_left == 0) begin
              m_phase = P_GAP; m_level--; m_ram ^= 1;
            end
          end else begin
`ifdef BC_TIMEOUT_EN
            m_wd++;
            if (m_wd == 16) begin m_err = 1; m_phase = P_IDLE; end
`endif
          end
        end
        P_GAP: begin
          if (m_level != 0) begin
            m_phase = P_REDUCE; m_left = 4 ** (m_level - 1); m_wd = 0;
          end else begin
            m_phase = P_FINISH;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // mode 0: load_done after 5 LOAD cycles, sqg_wen every 4th cycle.
  // mode 1: random load_done/sqg_wen, load_done also raised together with start.
  // mode 2: as mode 1 plus random start pulses while busy.
  task automatic drive_run(input int mode, input int stop_at, input int rst_at);
    int cyc;
    bit st, ld, wen, rs;
    cyc = 0; run_writes = 0; n_wr = 0; n_done = 0;
    valid_at.delete();
    do begin
      st  = (cyc == 0);
      ld  = (cyc == 0 && mode != 0);
      rs  = 1'b0;
      if (m_phase == P_LOAD) ld = (mode == 0) ? (cyc == 6) : ($urandom_range(0, 3) == 0);
      wen = (mode == 0) ? (cyc % 4 == 3) : bit'($urandom_range(0, 1));
      if (mode == 2 && cyc > 0) st = ($urandom_range(0, 5) == 0);
      if (stop_at >= 0 && run_writes >= stop_at) wen = 1'b0;
      if (rst_at >= 0 && run_writes == rst_at) begin rs = 1'b1; wen = 1'b0; end
      step(rs, st, ld, wen);
      cyc++;
    end while (m_phase != P_IDLE && cyc < 2000);
    step(0, 0, 0, 0);
    check("run_returns_idle", busy, 0);
  endtask

  task automatic check_full_run();
    int exp_at[3] = '{16, 20, 21};
    check("writes_total", n_wr, 21);
    check("done_pulses", n_done, 1);
    check("valid_count", valid_at.size(), 3);
    for (int i = 0; i < valid_at.size() && i < 3; i++)
      check($sformatf("valid_after_write[%0d]", i), valid_at[i], exp_at[i]);
    check("final_level", level, 0);
    check("final_ram_sel", ram_sel, 1);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; load_done = 1'b0; sqg_wen = 1'b0;
    repeat (2) @(posedge CLK);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);

    drive_run(0, -1, -1);
    check_full_run();

    for (int r = 0; r < 3; r++) begin
      drive_run(1, -1, -1);
      check_full_run();
    end
    for (int r = 0; r < 3; r++) begin
      drive_run(2, -1, -1);
      check_full_run();
    end

    drive_run(0, -1, 7);
    check("abort_busy", busy, 0);
    check("abort_level", level, 0);
    check("abort_bc_mode", bc_mode, 1);
    check("abort_writes", n_wr, 7);
    drive_run(0, -1, -1);
    check_full_run();

`ifdef BC_TIMEOUT_EN
    drive_run(0, 5, -1);
    check("wd_err", err, 1);
    check("wd_idle", busy, 0);
    check("wd_no_done", n_done, 0);
    check("wd_writes", n_wr, 5);
    drive_run(0, -1, -1);
    check("wd_err_cleared", err, 0);
    check_full_run();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
